uart128_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 128-bit UART transmit path (en_tx / data_in / u_tx_done) between NREQ requesters.
- Captures the granted requester's 128-bit word and drives en_tx through one complete frame.
- Detects completion, inserts an idle gap so the UART re-arms, and returns a per-requester done or timeout pulse.
- Sits between client logic and the UART top level, in the same clock domain.

---
 rtl/uart128_pkg.sv | 11 +
 rtl/rr_pick.sv | 21 ++
 rtl/uart128_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart128_tx_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart128_pkg.sv
// uart128_pkg: shared UART word width, arbiter state encoding and clog2 width helper
package uart128_pkg;
  localparam int UART_WORD_W = 128;
  typedef enum logic [1:0] {IDLE, LOAD, BUSY, GAP} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first req at or after ptr (req, ptr -> valid, idx)
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] k;
  always_comb begin
    valid = |req;
    idx = '0;
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % NREQ);
      if (req[k]) idx = k;
    end
  end
endmodule

// File: rtl/uart128_tx_arbiter.sv
// uart128_tx_arbiter: round-robin share of one 128-bit UART tx path; req/req_data in, gnt/done/timeout pulses, en_tx/tx_data to UART, u_tx_done from UART, busy status
module uart128_tx_arbiter
  import uart128_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*UART_WORD_W-1:0] req_data,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             done,
  output logic [NREQ-1:0]             timeout,
  output logic                        en_tx,
  output logic [UART_WORD_W-1:0]      tx_data,
  input  logic                        u_tx_done,
  output logic                        busy
);
  localparam int IW = clog2(NREQ);
  localparam int TW = clog2(TIMEOUT_CYCLES);
  localparam int GW = clog2(GAP_CYCLES + 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, rr_ptr, rr_ptr_n, pick_idx;
  logic [TW-1:0] timer, timer_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic armed, armed_n, pick_valid, fin, tmo;
  logic [NREQ-1:0] gnt_n, done_n, timeout_n;
  logic [UART_WORD_W-1:0] tx_data_n;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign en_tx = state == BUSY;
  assign busy = state != IDLE;
  // armed only sets once u_tx_done is seen low in BUSY, so a level left high from the previous frame is ignored
  assign fin = armed & u_tx_done;
  assign tmo = timer == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    idx_n = idx;
    rr_ptr_n = rr_ptr;
    timer_n = timer;
    gcnt_n = gcnt;
    armed_n = armed;
    gnt_n = gnt;
    done_n = '0;
    timeout_n = '0;
    tx_data_n = tx_data;
    case (state)
      IDLE: if (pick_valid) begin
        idx_n = pick_idx;
        tx_data_n = req_data[int'(pick_idx)*UART_WORD_W +: UART_WORD_W];
        gnt_n = NREQ'(1) << pick_idx;
        state_n = LOAD;
      end
      LOAD: begin
        timer_n = '0;
        armed_n = 1'b0;
        state_n = BUSY;
      end
      BUSY: begin
        timer_n = timer + 1'b1;
        armed_n = armed | ~u_tx_done;
        if (fin || tmo) begin
          done_n[idx] = fin;
          timeout_n[idx] = ~fin;
          gnt_n = '0;
          rr_ptr_n = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          gcnt_n = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        gcnt_n = gcnt + 1'b1;
        state_n = (gcnt == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      rr_ptr <= '0;
      timer <= '0;
      gcnt <= '0;
      armed <= 1'b0;
      gnt <= '0;
      done <= '0;
      timeout <= '0;
      tx_data <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      rr_ptr <= rr_ptr_n;
      timer <= timer_n;
      gcnt <= gcnt_n;
      armed <= armed_n;
      gnt <= gnt_n;
      done <= done_n;
      timeout <= timeout_n;
      tx_data <= tx_data_n;
    end
endmodule

// File: tb/tb_uart128_tx_arbiter.sv
// tb_uart128_tx_arbiter: table-driven frames with a scoreboard plus stale-done and mid-frame reset sequences
module tb_uart128_tx_arbiter;
  localparam int NREQ = 2;
  localparam int GAP = 4;
  localparam int TO = 64;
  localparam logic [127:0] W0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] W1 = 128'hfeedface0badf00d13572468a5a5c3c3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*128-1:0] req_data = {W1, W0};
  logic [NREQ-1:0] gnt, done, timeout;
  logic en_tx, busy, u_tx_done;
  logic [127:0] tx_data;
  logic uart_auto = 1'b1;
  logic u_auto = 1'b0;
  logic u_man = 1'b0;
  int lat = 0;
  int ucnt = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {int idx; logic [127:0] word; logic to;} exp_t;
  typedef struct {logic [NREQ-1:0] r; int lat; int idx; logic to; logic drop;} vec_t;
  exp_t sb[$];
  vec_t vecs[9];
  uart128_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .done(done),
    .timeout(timeout),
    .en_tx(en_tx),
    .tx_data(tx_data),
    .u_tx_done(u_tx_done),
    .busy(busy)
  );
  assign u_tx_done = uart_auto ? u_auto : u_man;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!en_tx) begin
      ucnt = 0;
      u_auto = 1'b0;
    end else begin
      ucnt++;
      if (ucnt == lat) u_auto = 1'b1;
    end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] word_of(input int i);
    return i == 0 ? W0 : W1;
  endfunction
  task automatic start_frame(input logic [NREQ-1:0] r, input int i, input logic to);
    exp_t e;
    for (int k = 0; k < 200 && busy; k++) tick();
    chk("idle_before_req", busy, 0);
    req = r;
    tick();
    chk("gnt", gnt, 1 << i);
    chk("load_en_tx", en_tx, 0);
    chk("tx_data", tx_data, word_of(i));
    e.idx = i;
    e.word = word_of(i);
    e.to = to;
    sb.push_back(e);
    tick();
    chk("busy_en_tx", en_tx, 1);
  endtask
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("done", done, e.to ? 0 : 1 << e.idx);
    chk("timeout", timeout, e.to ? 1 << e.idx : 0);
    chk("end_en_tx", en_tx, 0);
    chk("end_gnt", gnt, 0);
    chk("tx_data_hold", tx_data, e.word);
  endtask
  task automatic finish_frame(input int cyc);
    int n = 1;
    for (int k = 0; k < TO + 20 && !(|done || |timeout); k++) begin
      tick();
      if (!(|done || |timeout)) n++;
    end
    chk("en_tx_cycles", n, cyc);
    pop_check();
  endtask
  task automatic gap_check();
    int n = 0;
    logic bad = 1'b0;
    while (busy && n < GAP + 10) begin
      tick();
      n++;
      bad |= en_tx | (|done) | (|timeout);
    end
    chk("gap_len", n, GAP);
    chk("gap_quiet", bad, 0);
  endtask
  initial begin
    vecs[0] = '{2'b01, 50, 0, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 20, 1, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 20, 0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 20, 1, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 20, 0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 0, 0, 1'b1, 1'b0};
    vecs[6] = '{2'b11, TO, 1, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 5, 1, 1'b0, 1'b1};
    vecs[8] = '{2'b01, 3, 0, 1'b0, 1'b0};
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_en_tx", en_tx, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      start_frame(vecs[v].r, vecs[v].idx, vecs[v].to);
      if (vecs[v].drop) req = '0;
      finish_frame(vecs[v].to ? TO : vecs[v].lat);
      gap_check();
    end
    uart_auto = 1'b0;
    u_man = 1'b1;
    start_frame(2'b01, 0, 1'b0);
    req = '0;
    req_data[127:0] = ~W0;
    repeat (2) begin
      tick();
      chk("stale_high_no_done", done, 0);
    end
    u_man = 1'b0;
    repeat (10) begin
      tick();
      chk("stale_low_no_done", done, 0);
    end
    u_man = 1'b1;
    tick();
    pop_check();
    u_man = 1'b0;
    uart_auto = 1'b1;
    req_data[127:0] = W0;
    gap_check();
    lat = 0;
    start_frame(2'b01, 0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_en_tx", en_tx, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulses", {done, timeout}, 0);
    void'(sb.pop_back());
    rst = 1'b0;
    lat = 5;
    start_frame(2'b10, 1, 1'b0);
    req = '0;
    finish_frame(5);
    gap_check();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
